// File: rtl/d_ff_pipe.sv
// Parameterised register pipeline with per-stage valid bits, occupancy count,
// synchronous clear/preset/stall and an async active-low reset with synchronised release.
module d_ff_pipe #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1,
    localparam int              CW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preset,
    input  logic             clear,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             out_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_shift;
    logic             run_en;

    // Release flop: the edge that samples reset high only arms the pipeline,
    // so the first state change lands on the second edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    always_comb begin
        count_shift = count_q + CW'(in_valid) - CW'(vld_q[DEPTH-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            vld_q   <= '0;
            count_q <= '0;
        end else if (run_en) begin
            if (clear) begin
                for (int k = 0; k < DEPTH; k++) begin
                    data_q[k] <= '0;
                end
                vld_q   <= '0;
                count_q <= '0;
            end else if (preset) begin
                for (int k = 0; k < DEPTH; k++) begin
                    data_q[k] <= PRESET_VAL;
                end
                vld_q   <= '1;
                count_q <= CW'(DEPTH);
            end else if (!stall) begin
                // Invalid data still shifts; only the valid bits feed the count.
                data_q[0] <= d;
                vld_q[0]  <= in_valid;
                for (int k = 1; k < DEPTH; k++) begin
                    data_q[k] <= data_q[k-1];
                    vld_q[k]  <= vld_q[k-1];
                end
                count_q <= count_shift;
            end
        end
    end

    assign q         = data_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];
    assign count     = count_q;

endmodule
